kyber_phase_sequencer: RTL
==========================

// Module: kyber_phase_sequencer
// PURPOSE
//  Top-level phase sequencer for the Kyber512 encryption datapath. Drives the 4-bit
//  cstate bus that selects which phase engine owns the shared M2 BRAM port through the
//  BRAM mux. Issues a one-cycle start pulse to each phase engine and advances on that
//  engine's done pulse. Loops PAcc->INTT->Add->Reduce once per output polynomial row,
//  and aborts to IDLE with a sticky error if an engine stalls.
// PARAMETERS
//  ROWS     3     PAcc..Reduce loop iterations (K=2 rows of u, plus 1 for v); must be >= 1
//  ROW_W    2     width of row_idx; must satisfy 2**ROW_W >= ROWS
//  TIMEOUT  4095  max cycles in any non-IDLE state without phase_done; 0 disables watchdog
//  TO_W     12    watchdog counter width; must satisfy 2**TO_W > TIMEOUT
// PORTS
//  clk          in   1      system clock; all logic on rising edge
//  rst          in   1      synchronous, active-high reset
//  start        in   1      request one encryption; sampled only in IDLE
//  phase_done   in   1      one-cycle done pulse from the engine owning the current cstate
//  cstate       out  4      current phase: IDLE=0 Unpack=1 Hash=2 NTT=3 PAcc=4 INTT=5
//                           Add=6 Reduce=7 Pack=8; other codes are never driven
//  phase_start  out  1      one-cycle pulse in the first cycle of each non-IDLE state
//  row_idx      out  ROW_W  current row for PAcc/INTT/Add/Reduce; 0 in all other states
//  busy         out  1      1 whenever cstate != IDLE
//  done         out  1      one-cycle pulse on the cycle IDLE is re-entered after Pack
//  err          out  1      sticky watchdog flag; cleared by rst or by an accepted start
// BEHAVIOUR
//  Reset: all outputs and state are registered. On rst: cstate=IDLE, phase_start=0,
//   row_idx=0, busy=0, done=0, err=0, watchdog=0. rst has priority over every other event,
//   including mid-phase reset. The next edge after rst returns to IDLE with no done pulse.
//  FSM sequence: IDLE -> Unpack -> Hash -> NTT -> PAcc -> INTT -> Add -> Reduce -> [loop] -> Pack -> IDLE.
//  Loop rule: on Reduce+phase_done, if row_idx < ROWS-1 then row_idx++ and go to PAcc;
//   otherwise row_idx stays (zeroed at Pack) and go to Pack.
//  Start: start=1 in IDLE at edge t gives cstate=Unpack, phase_start=1 and err=0 at t+1.
//   start in any other state is ignored (no queuing).
//  Advance: phase_done=1 in state S at edge t gives the next state and phase_start=1 at t+1.
//   Minimum dwell is 1 cycle. phase_done is accepted in the same cycle as phase_start.
//  phase_done in IDLE is ignored. Engines must not assert it otherwise.
//  Completion: Pack+phase_done at t gives cstate=IDLE, done=1 at t+1, and done=0 at t+2.
//   start is sampled from t+1, so back-to-back runs are allowed.
//  Watchdog: the counter clears on every state entry and counts each non-IDLE cycle
//   without phase_done. When the count reaches TIMEOUT, the next edge forces cstate=IDLE,
//   row_idx=0 and err=1, with no done pulse. phase_done in the same cycle wins (normal advance).
//  Width: the row_idx increment never wraps, given ROWS <= 2**ROW_W. The watchdog saturates.
// TESTING
//  T1 reset, start pulse, each engine done 2 cycles after its phase_start
//   -> cstate 0,1,2,3,(4,5,6,7)x3,8,0; row_idx 0,1,2 in the loops; single done pulse.
//  T2 phase_done coincident with every phase_start (zero-latency engines)
//   -> each state is held exactly 1 cycle; total 15 cycles from start to done.
//  T3 start held high continuously
//   -> a new run begins on the cycle after done; start pulses mid-run have no effect.
//  T4 TIMEOUT=8, no phase_done in NTT
//   -> after 9 cycles in NTT: cstate=0, err=1, done=0. The next start clears err.
//  T5 rst asserted in INTT with row_idx=1
//   -> next edge: cstate=0, row_idx=0, busy=0; no done pulse. A fresh run then completes normally.
//  T6 phase_done pulses while in IDLE, and start+rst together
//   -> remains in IDLE; no phase_start.

Source files
------------

// File: rtl/kyber_phase_sequencer_if.sv
// kyber_phase_sequencer_if: start/done handshake and phase-select bus between the sequencer and its environment
interface kyber_phase_sequencer_if #(parameter int ROW_W = 2);
  logic start, phase_done, phase_start, busy, done, err;
  logic [3:0] cstate;
  logic [ROW_W-1:0] row_idx;
  modport master(input start, phase_done, output cstate, phase_start, row_idx, busy, done, err);
  modport slave(output start, phase_done, input cstate, phase_start, row_idx, busy, done, err);
endinterface

// File: rtl/kyber_phase_sequencer.sv
// kyber_phase_sequencer: steps the Kyber512 encryption phases, loops PAcc..Reduce per row, aborts on a stalled engine
module kyber_phase_sequencer #(
  parameter int ROWS = 3,
  parameter int ROW_W = 2,
  parameter int TIMEOUT = 4095,
  parameter int TO_W = 12
) (
  input logic clk,
  input logic rst,
  kyber_phase_sequencer_if.master bus
);
  typedef enum logic [3:0] {IDLE, UNPACK, HASH, NTT, PACC, INTT, ADD, REDUCE, PACK} state_t;
  localparam logic [ROW_W-1:0] LAST = ROW_W'(ROWS - 1);
  localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT);
  state_t state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [TO_W-1:0] wd_q, wd_d;
  logic ps_q, ps_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic last_row, expired;
  assign last_row = row_q >= LAST;
  assign expired = (TIMEOUT != 0) && (wd_q >= LIMIT) && (state_q != IDLE);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q <= '0;
      wd_q <= '0;
      ps_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q <= row_d;
      wd_q <= wd_d;
      ps_q <= ps_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) state_d = bus.start ? UNPACK : IDLE;
    else if (bus.phase_done)
      state_d = state_q == REDUCE ? (last_row ? PACK : PACC) :
                state_q == PACK ? IDLE : state_t'(state_q + 4'd1);
    else if (expired) state_d = IDLE;
  end
  // Row only advances on the Reduce->PAcc loop-back and is zero outside the row loop.
  always_comb begin
    row_d = !(state_d inside {PACC, INTT, ADD, REDUCE}) ? '0 :
            (state_q == REDUCE && state_d == PACC) ? row_q + 1'b1 : row_q;
    wd_d = (state_d != state_q || state_q == IDLE) ? '0 : wd_q + TO_W'(!(&wd_q));
    ps_d = state_d != state_q && state_d != IDLE;
    busy_d = state_d != IDLE;
    done_d = state_q == PACK && bus.phase_done;
    err_d = (state_q == IDLE && bus.start) ? 1'b0 : (expired && !bus.phase_done) ? 1'b1 : err_q;
  end
  assign bus.cstate = state_q;
  assign bus.row_idx = row_q;
  assign bus.phase_start = ps_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.err = err_q;
endmodule
